instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_if.sv | 26 ++
 rtl/instruction_fetch_unit.sv | 104 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Control/memory-facing bundle of the instruction fetch unit.
// The fetch unit takes the slave view; the control unit / memory model takes the master view.
interface instruction_fetch_unit_if;
    logic        fetch_req;
    logic        pc_load;
    logic [1:0]  pc_src;
    logic        push;
    logic [15:0] target;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] ir;
    logic [15:0] pc;
    logic        ir_valid;
    logic        busy;
    logic [2:0]  fault;

    modport master (
        output fetch_req, pc_load, pc_src, push, target, imem_data,
        input  imem_addr, ir, pc, ir_valid, busy, fault
    );

    modport slave (
        input  fetch_req, pc_load, pc_src, push, target, imem_data,
        output imem_addr, ir, pc, ir_valid, busy, fault
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/HOLD sequencer, PC update logic and a
// small return-address stack with sticky fault reporting.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          RAS_DEPTH  = 4,
    parameter int          IMEM_BYTES = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    instruction_fetch_unit_if.slave  bus
);
    localparam int              SPW       = $clog2(RAS_DEPTH + 1);
    localparam int              AW        = $clog2(RAS_DEPTH);
    localparam logic [SPW-1:0]  FULL      = SPW'(RAS_DEPTH);
    localparam logic [15:0]     LAST_ADDR = 16'(IMEM_BYTES - 2);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t          state_q, state_d;
    logic [15:0]     pc_q, ir_q;
    logic            ir_valid_q;
    logic [2:0]      fault_q;
    logic [SPW-1:0]  sp_q;
    // Storage rounded up to a power of two so the AW-bit index is always in range.
    logic [15:0]     ras [0:(1<<AW)-1];

    logic            fetch_done, do_load;
    logic            is_jump, do_push, push_ok, do_pop, pop_ok, out_of_range;
    logic [15:0]     pc_inc, tgt, pc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        fetch_done = 1'b0;
        do_load    = 1'b0;
        case (state_q)
            IDLE:  if (bus.fetch_req) state_d = FETCH;
            FETCH: begin
                fetch_done = 1'b1;
                state_d    = HOLD;
            end
            HOLD:  if (bus.pc_load) begin
                do_load = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_inc       = pc_q + 16'd2;
        tgt          = {bus.target[15:1], 1'b0};
        out_of_range = pc_q > LAST_ADDR;
        is_jump      = do_load && (bus.pc_src == 2'b01 || bus.pc_src == 2'b10);
        do_push      = do_load && bus.pc_src == 2'b10 && bus.push;
        push_ok      = do_push && sp_q != FULL;
        do_pop       = do_load && bus.pc_src == 2'b11;
        pop_ok       = do_pop && sp_q != '0;
        pc_next      = pc_inc;
        case (bus.pc_src)
            2'b01, 2'b10: pc_next = tgt;
            2'b11:        pc_next = pop_ok ? ras[AW'(sp_q - SPW'(1))] : pc_inc;
            default:      pc_next = pc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            fault_q    <= '0;
            sp_q       <= '0;
        end else begin
            ir_valid_q <= fetch_done;
            if (fetch_done) begin
                // Addresses past the last full word read as zero and flag a fault.
                ir_q <= out_of_range ? 16'h0000 : bus.imem_data;
                if (out_of_range) fault_q[2] <= 1'b1;
            end
            if (do_load)              pc_q       <= pc_next;
            if (is_jump && bus.target[0]) fault_q[0] <= 1'b1;
            if (do_push && !push_ok)  fault_q[1] <= 1'b1;
            if (do_pop && !pop_ok)    fault_q[2] <= 1'b1;
            if (push_ok)              sp_q <= sp_q + SPW'(1);
            else if (pop_ok)          sp_q <= sp_q - SPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) ras[AW'(sp_q)] <= pc_inc;
    end

    assign bus.imem_addr = pc_q;
    assign bus.pc        = pc_q;
    assign bus.ir        = ir_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.fault     = fault_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios then random fetch/update
// traffic, all checked against a queue-based model of the PC and return stack.
module tb_instruction_fetch_unit;
    localparam logic [15:0] RESET_PC   = 16'h0000;
    localparam int          RAS_DEPTH  = 4;
    localparam int          IMEM_BYTES = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .RAS_DEPTH  (RAS_DEPTH),
        .IMEM_BYTES (IMEM_BYTES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] mem [0:IMEM_BYTES-1];

    always_comb begin
        bus.imem_data = 16'hDEAD;
        if (int'(bus.imem_addr) <= IMEM_BYTES - 2)
            bus.imem_data = {mem[int'(bus.imem_addr) + 1], mem[int'(bus.imem_addr)]};
    end

    // Reference model state
    logic [15:0] m_pc;
    logic [2:0]  m_fault;
    logic [15:0] m_ras [$];
    logic [15:0] m_ir;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_fault = 3'b000;
        m_ras.delete();
        m_ir    = 16'h0000;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_pc", 32'(bus.pc), 32'(m_pc));
        check("rst_fault", 32'(bus.fault), 32'(m_fault));
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Expects IDLE on entry; leaves the unit in HOLD.
    task automatic do_fetch(input string tag);
        bus.fetch_req = 1'b1;
        @(posedge clk); #1;
        bus.fetch_req = 1'b0;
        check({tag, "_fetch_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_fetch_nvld"}, 32'(bus.ir_valid), 32'd0);
        check({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'(m_pc));
        if (int'(m_pc) <= IMEM_BYTES - 2) m_ir = {mem[int'(m_pc) + 1], mem[int'(m_pc)]};
        else begin
            m_ir = 16'h0000;
            m_fault[2] = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, "_vld"}, 32'(bus.ir_valid), 32'd1);
        check({tag, "_ir"}, 32'(bus.ir), 32'(m_ir));
        check({tag, "_fault"}, 32'(bus.fault), 32'(m_fault));
        @(posedge clk); #1;
        check({tag, "_vld_drop"}, 32'(bus.ir_valid), 32'd0);
        check({tag, "_hold_busy"}, 32'(bus.busy), 32'd1);
    endtask

    // Expects HOLD on entry; leaves the unit in IDLE.
    task automatic do_load(input string tag, input logic [1:0] src, input logic psh, input logic [15:0] t);
        logic [15:0] nxt;
        bus.pc_load = 1'b1;
        bus.pc_src  = src;
        bus.push    = psh;
        bus.target  = t;
        @(posedge clk); #1;
        bus.pc_load = 1'b0;
        bus.push    = 1'b0;
        nxt = m_pc + 16'd2;
        if (src == 2'b01 || src == 2'b10) begin
            if (t[0]) m_fault[0] = 1'b1;
            if (src == 2'b10 && psh) begin
                if (m_ras.size() == RAS_DEPTH) m_fault[1] = 1'b1;
                else m_ras.push_back(m_pc + 16'd2);
            end
            nxt = t & 16'hFFFE;
        end else if (src == 2'b11) begin
            if (m_ras.size() == 0) m_fault[2] = 1'b1;
            else nxt = m_ras.pop_back();
        end
        m_pc = nxt;
        check({tag, "_pc"}, 32'(bus.pc), 32'(m_pc));
        check({tag, "_fault"}, 32'(bus.fault), 32'(m_fault));
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
        check({tag, "_ir_kept"}, 32'(bus.ir), 32'(m_ir));
    endtask

    initial begin
        bus.fetch_req = 1'b0;
        bus.pc_load   = 1'b0;
        bus.pc_src    = 2'b00;
        bus.push      = 1'b0;
        bus.target    = 16'h0000;
        for (int i = 0; i < IMEM_BYTES; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h21;
        mem[1] = 8'h42;

        apply_reset();
        check("rst_ir", 32'(bus.ir), 32'h0);
        check("rst_vld", 32'(bus.ir_valid), 32'h0);

        // pc_load in IDLE must be ignored
        bus.pc_load = 1'b1;
        bus.pc_src  = 2'b01;
        bus.target  = 16'h0020;
        @(posedge clk); #1;
        bus.pc_load = 1'b0;
        check("idle_load_pc", 32'(bus.pc), 32'(m_pc));
        check("idle_load_busy", 32'(bus.busy), 32'd0);

        // V1
        do_fetch("v1");
        check("v1_ir_const", 32'(bus.ir), 32'h4221);
        bus.fetch_req = 1'b1;                        // ignored in HOLD
        @(posedge clk); #1;
        bus.fetch_req = 1'b0;
        check("v1_hold_nvld", 32'(bus.ir_valid), 32'd0);
        check("v1_hold_busy", 32'(bus.busy), 32'd1);
        do_load("v1_ld", 2'b00, 1'b0, 16'h0000);
        check("v1_pc2", 32'(bus.pc), 32'd2);

        // V2
        do_fetch("v2a");
        do_load("v2_call", 2'b10, 1'b1, 16'h0006);
        check("v2_pc6", 32'(bus.pc), 32'd6);
        do_fetch("v2b");
        do_load("v2_ret", 2'b11, 1'b0, 16'h0000);
        check("v2_pc4", 32'(bus.pc), 32'd4);

        // V3: five calls overflow a 4-deep stack, five returns underflow it
        for (int i = 0; i < 5; i++) begin
            do_fetch("v3c");
            do_load("v3_call", 2'b10, 1'b1, 16'(10 * (i + 1)));
        end
        check("v3_ovf", 32'(bus.fault[1]), 32'd1);
        check("v3_pc50", 32'(bus.pc), 32'd50);
        for (int i = 0; i < 5; i++) begin
            do_fetch("v3r");
            do_load("v3_ret", 2'b11, 1'b1, 16'h0000);
        end
        check("v3_unf", 32'(bus.fault[2]), 32'd1);

        apply_reset();

        // V4
        do_fetch("v4");
        do_load("v4_br", 2'b01, 1'b0, 16'h0009);
        check("v4_pc8", 32'(bus.pc), 32'd8);
        check("v4_mis", 32'(bus.fault), 32'b001);

        // V5
        do_fetch("v5a");
        do_load("v5_br", 2'b01, 1'b0, 16'd62);
        do_fetch("v5b");
        check("v5_no_oor", 32'(bus.fault[2]), 32'd0);
        do_load("v5_inc", 2'b00, 1'b0, 16'h0000);
        check("v5_pc64", 32'(bus.pc), 32'd64);
        do_fetch("v5c");
        check("v5_ir0", 32'(bus.ir), 32'd0);
        check("v5_oor", 32'(bus.fault[2]), 32'd1);
        do_load("v5_back", 2'b01, 1'b0, 16'd12);

        // V6: reset mid-FETCH
        bus.fetch_req = 1'b1;
        @(posedge clk); #1;
        bus.fetch_req = 1'b0;
        check("v6_in_fetch", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("v6_busy", 32'(bus.busy), 32'd0);
        check("v6_pc", 32'(bus.pc), 32'(RESET_PC));
        check("v6_fault", 32'(bus.fault), 32'd0);
        @(posedge clk); #1;
        check("v6_nvld", 32'(bus.ir_valid), 32'd0);
        check("v6_ir", 32'(bus.ir), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Random traffic against the model
        for (int i = 0; i < 150; i++) begin
            logic [1:0]  src;
            logic        psh;
            logic [15:0] t;
            src = 2'($urandom_range(0, 3));
            psh = 1'($urandom_range(0, 1));
            t   = 16'($urandom_range(0, 70));
            do_fetch("rnd");
            do_load("rnd_ld", src, psh, t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
